// File: rtl/spr_line_writer.sv
// Sprite line writer: expands 8-pixel slivers into a 256-entry line buffer with an occupancy bitmap.
// Optional per-line sliver limit with a sticky overflow flag is enabled by the SPR_TIME_OVER_EN macro.
module spr_line_writer #(
  parameter int unsigned MAX_SLIVERS = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [8:0]  s_x,
  input  logic [31:0] s_planes,
  input  logic [2:0]  s_pal,
  input  logic [1:0]  s_pri,
  input  logic        s_hflip,
  output logic        lb_we,
  output logic [7:0]  lb_addr,
  output logic [8:0]  lb_din,
  input  logic        rd_en,
  input  logic [7:0]  rd_x,
  output logic [7:0]  lb_raddr,
  input  logic [8:0]  lb_dout,
  output logic [8:0]  rd_pix,
  output logic        rd_opaque,
  output logic        time_over
);

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [2:0]   i_q, i_d;
  logic [8:0]   x_q, x_d;
  logic [31:0]  planes_q, planes_d;
  logic [2:0]   pal_q, pal_d;
  logic [1:0]   pri_q, pri_d;
  logic         hflip_q, hflip_d;
  logic         lb_we_q, lb_we_d;
  logic [7:0]   lb_addr_q, lb_addr_d;
  logic [8:0]   lb_din_q, lb_din_d;
  logic [255:0] occ_q, occ_d;
  logic         rd_pend_q, rd_pend_d;
  logic         rd_occ_q, rd_occ_d;
  logic [8:0]   rd_pix_q, rd_pix_d;
  logic         rd_opaque_q, rd_opaque_d;

  logic         accept;
  logic         drop_sel;
  logic [8:0]   sel_x;
  logic [31:0]  sel_planes;
  logic [2:0]   sel_pal;
  logic [1:0]   sel_pri;
  logic         sel_hflip;
  logic [2:0]   sel_idx;
  logic [12:0]  pix;
  logic         write_ok;

  // Returns {x[8:0], color[3:0]} for pixel idx of a sliver.
  function automatic logic [12:0] pixel(input logic [8:0] base, input logic [31:0] pl,
                                        input logic [2:0] idx, input logic hf);
    logic [2:0] b;
    logic [8:0] x;
    b = hf ? idx : (3'd7 - idx);
    x = base + {6'd0, idx};
    return {x, pl[{2'd3, b}], pl[{2'd2, b}], pl[{2'd1, b}], pl[{2'd0, b}]};
  endfunction

  assign s_ready   = ((state_q == IDLE) || ((state_q == WRITE) && (i_q == 3'd7))) && !line_start;
  assign accept    = s_valid && s_ready;
  assign lb_raddr  = rd_x;
  assign lb_we     = lb_we_q;
  assign lb_addr   = lb_addr_q;
  assign lb_din    = lb_din_q;
  assign rd_pix    = rd_pix_q;
  assign rd_opaque = rd_opaque_q;

`ifdef SPR_TIME_OVER_EN
  logic [5:0] cnt_q, cnt_d;
  logic       drop_q, drop_d;
  logic       time_over_q, time_over_d;
  logic       drop_now;

  always_comb begin
    drop_now    = ({26'd0, cnt_q} >= MAX_SLIVERS);
    drop_sel    = accept ? drop_now : drop_q;
    drop_d      = drop_sel;
    cnt_d       = cnt_q;
    time_over_d = time_over_q;
    if (line_start) begin
      cnt_d       = 6'd0;
      time_over_d = 1'b0;
    end else if (accept) begin
      if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
      if (drop_now) time_over_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 6'd0;
      drop_q      <= 1'b0;
      time_over_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      time_over_q <= time_over_d;
    end
  end

  assign time_over = time_over_q;
`else
  logic unused_max_slivers;
  assign unused_max_slivers = |MAX_SLIVERS;
  assign drop_sel  = 1'b0;
  assign time_over = 1'b0;
`endif

  // The next pixel is taken from the incoming sliver on acceptance so that lb_we lines up with counter i.
  always_comb begin
    sel_x      = accept ? s_x      : x_q;
    sel_planes = accept ? s_planes : planes_q;
    sel_pal    = accept ? s_pal    : pal_q;
    sel_pri    = accept ? s_pri    : pri_q;
    sel_hflip  = accept ? s_hflip  : hflip_q;
    sel_idx    = accept ? 3'd0     : (i_q + 3'd1);
    pix        = pixel(sel_x, sel_planes, sel_idx, sel_hflip);
    // A write still on the port has not reached occ yet, so it is checked separately.
    write_ok   = (pix[3:0] != 4'd0) && !pix[12] && !occ_q[pix[11:4]] && !drop_sel &&
                 !(lb_we_q && (lb_addr_q == pix[11:4]));

    state_d   = state_q;
    i_d       = i_q;
    x_d       = x_q;
    planes_d  = planes_q;
    pal_d     = pal_q;
    pri_d     = pri_q;
    hflip_d   = hflip_q;
    lb_we_d   = 1'b0;
    lb_addr_d = lb_addr_q;
    lb_din_d  = lb_din_q;

    if (line_start) begin
      state_d = IDLE;
      i_d     = 3'd0;
    end else if (accept || ((state_q == WRITE) && (i_q != 3'd7))) begin
      state_d   = WRITE;
      i_d       = sel_idx;
      x_d       = sel_x;
      planes_d  = sel_planes;
      pal_d     = sel_pal;
      pri_d     = sel_pri;
      hflip_d   = sel_hflip;
      lb_we_d   = write_ok;
      lb_addr_d = pix[11:4];
      lb_din_d  = {sel_pri, sel_pal, pix[3:0]};
    end else begin
      state_d = IDLE;
      i_d     = 3'd0;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (line_start) begin
      occ_d = '0;
    end else if (lb_we_q) begin
      occ_d[lb_addr_q] = 1'b1;
    end

    rd_pend_d   = rd_en;
    rd_occ_d    = rd_en ? occ_q[rd_x] : rd_occ_q;
    rd_pix_d    = rd_pix_q;
    rd_opaque_d = rd_opaque_q;
    if (rd_pend_q) begin
      rd_pix_d    = rd_occ_q ? lb_dout : 9'h000;
      rd_opaque_d = rd_occ_q;
    end else begin
      rd_pix_d    = rd_pix_q;
      rd_opaque_d = rd_opaque_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= 3'd0;
      x_q         <= 9'd0;
      planes_q    <= 32'd0;
      pal_q       <= 3'd0;
      pri_q       <= 2'd0;
      hflip_q     <= 1'b0;
      lb_we_q     <= 1'b0;
      lb_addr_q   <= 8'd0;
      lb_din_q    <= 9'd0;
      occ_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_occ_q    <= 1'b0;
      rd_pix_q    <= 9'd0;
      rd_opaque_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      x_q         <= x_d;
      planes_q    <= planes_d;
      pal_q       <= pal_d;
      pri_q       <= pri_d;
      hflip_q     <= hflip_d;
      lb_we_q     <= lb_we_d;
      lb_addr_q   <= lb_addr_d;
      lb_din_q    <= lb_din_d;
      occ_q       <= occ_d;
      rd_pend_q   <= rd_pend_d;
      rd_occ_q    <= rd_occ_d;
      rd_pix_q    <= rd_pix_d;
      rd_opaque_q <= rd_opaque_d;
    end
  end

endmodule

// File: tb/tb_spr_line_writer.sv
// Scoreboard bench for spr_line_writer: expected line-buffer writes are queued at sliver acceptance.
module tb_spr_line_writer;

  localparam int unsigned MAXS = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [8:0]  s_x = 9'd0;
  logic [31:0] s_planes = 32'd0;
  logic [2:0]  s_pal = 3'd0;
  logic [1:0]  s_pri = 2'd0;
  logic        s_hflip = 1'b0;
  logic        lb_we;
  logic [7:0]  lb_addr;
  logic [8:0]  lb_din;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_x = 8'd0;
  logic [7:0]  lb_raddr;
  logic [8:0]  lb_dout;
  logic [8:0]  rd_pix;
  logic        rd_opaque;
  logic        time_over;

  int checks = 0;
  int errors = 0;

  logic [16:0]  exp_q[$];
  logic [16:0]  mon_e;
  logic [255:0] m_occ = '0;
  logic [8:0]   m_pix [256];
  logic [8:0]   lb_mem [256];
  int           m_cnt = 0;
  logic         exp_to = 1'b0;

  spr_line_writer #(.MAX_SLIVERS(MAXS)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_planes(s_planes), .s_pal(s_pal), .s_pri(s_pri), .s_hflip(s_hflip),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_din(lb_din), .rd_en(rd_en), .rd_x(rd_x),
    .lb_raddr(lb_raddr), .lb_dout(lb_dout), .rd_pix(rd_pix), .rd_opaque(rd_opaque),
    .time_over(time_over)
  );

  always #5 clk = ~clk;

  // Line buffer with one-cycle read latency, old data on read-during-write.
  always @(posedge clk) begin
    if (lb_we) lb_mem[lb_addr] <= lb_din;
    lb_dout <= lb_mem[lb_raddr];
  end

  always @(negedge clk) begin
    if (!rst && lb_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL lb_write_unexpected: got addr %0d din %h, expected no write", lb_addr, lb_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ({lb_addr, lb_din} !== mon_e) begin
          errors++;
          $display("FAIL lb_write: got addr %0d din %h, expected addr %0d din %h",
                   lb_addr, lb_din, mon_e[16:9], mon_e[8:0]);
        end
      end
    end
  end

  task automatic model_accept(input logic [8:0] x, input logic [31:0] pl, input logic [2:0] pal,
                              input logic [1:0] pri, input logic hf);
    logic drop = 1'b0;
    logic [2:0] b;
    logic [3:0] c;
    logic [8:0] px;
`ifdef SPR_TIME_OVER_EN
    if (m_cnt >= MAXS) begin
      drop = 1'b1;
      exp_to = 1'b1;
    end
    if (m_cnt < 63) m_cnt++;
`endif
    for (int i = 0; i < 8; i++) begin
      b  = hf ? 3'(i) : 3'(7 - i);
      c  = {pl[24 + b], pl[16 + b], pl[8 + b], pl[b]};
      px = x + 9'(i);
      if (!drop && c != 4'd0 && !px[8] && !m_occ[px[7:0]]) begin
        m_occ[px[7:0]] = 1'b1;
        m_pix[px[7:0]] = {pri, pal, c};
        exp_q.push_back({px[7:0], pri, pal, c});
      end
    end
  endtask

  task automatic send(input logic [8:0] x, input logic [31:0] pl, input logic [2:0] pal,
                      input logic [1:0] pri, input logic hf);
    logic acc = 1'b0;
    int waited = 0;
    s_x = x; s_planes = pl; s_pal = pal; s_pri = pri; s_hflip = hf; s_valid = 1'b1;
    while (!acc && waited < 40) begin
      @(negedge clk);
      if (s_ready) acc = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    s_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: got s_ready low for %0d cycles, expected acceptance", waited);
    end else begin
      model_accept(x, pl, pal, pri, hf);
    end
  endtask

  task automatic do_line_start();
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    m_occ = '0;
    m_cnt = 0;
    exp_to = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_missing: got %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_read(input logic [7:0] x);
    logic       eo;
    logic [8:0] ep;
    eo = m_occ[x];
    ep = eo ? m_pix[x] : 9'h000;
    rd_en = 1'b1; rd_x = x;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    checks += 2;
    if (rd_opaque !== eo) begin
      errors++;
      $display("FAIL rd_opaque x=%0d: got %b, expected %b", x, rd_opaque, eo);
    end
    if (rd_pix !== ep) begin
      errors++;
      $display("FAIL rd_pix x=%0d: got %h, expected %h", x, rd_pix, ep);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if ({lb_we, lb_addr, lb_din} !== 18'd0) begin
      errors++;
      $display("FAIL reset_lb: got we %b addr %h din %h, expected all 0", lb_we, lb_addr, lb_din);
    end
    if ({rd_pix, rd_opaque, time_over} !== 11'd0) begin
      errors++;
      $display("FAIL reset_rd: got pix %h opq %b to %b, expected all 0", rd_pix, rd_opaque, time_over);
    end
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, expected 1", s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_line_start();
    send(9'd10, 32'h0000_0080, 3'd3, 2'd2, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    do_line_start();
    send(9'd10, 32'h0000_0080, 3'd3, 2'd2, 1'b1);
    t0 = $time;
    send(9'd10, 32'h0000_00FF, 3'd3, 2'd2, 1'b0);
    checks++;
    if ($time - t0 != 80) begin
      errors++;
      $display("FAIL b2b_spacing: got %0t, expected 80", $time - t0);
    end
    drain();
    do_read(8'd17);
    do_read(8'd12);
  endtask

  task automatic test_wrap();
    do_line_start();
    send(9'h1FC, 32'h0000_00FF, 3'd1, 2'd1, 1'b0);
    send(9'd252, 32'h0000_00FF, 3'd5, 2'd0, 1'b0);
    drain();
  endtask

  task automatic test_read();
    logic [8:0] held;
    do_line_start();
    send(9'd40, 32'h0080_0080, 3'd2, 2'd3, 1'b0);
    drain();
    do_read(8'd40);
    checks++;
    if (rd_pix !== 9'h1A5) begin
      errors++;
      $display("FAIL rd_x40: got %h, expected 1a5", rd_pix);
    end
    held = rd_pix;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rd_pix !== held) begin
      errors++;
      $display("FAIL rd_hold: got %h, expected %h", rd_pix, held);
    end
    do_read(8'd41);
  endtask

  task automatic test_rw_collision();
    do_line_start();
    send(9'd60, 32'h0000_0080, 3'd4, 2'd1, 1'b0);
    rd_en = 1'b1; rd_x = 8'd60;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rd_opaque, rd_pix} !== 10'd0) begin
      errors++;
      $display("FAIL rw_same_x: got opq %b pix %h, expected 0 000", rd_opaque, rd_pix);
    end
    drain();
    do_read(8'd60);
  endtask

  task automatic test_line_start_abort();
    logic [8:0] ep;
    do_line_start();
    send(9'd100, 32'h0000_00FF, 3'd6, 2'd3, 1'b0);
    repeat (4) void'(exp_q.pop_back());
    ep = m_pix[100];
    repeat (3) @(posedge clk);
    #1;
    line_start = 1'b1; s_valid = 1'b1; rd_en = 1'b1; rd_x = 8'd100;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_on_line_start: got %b, expected 0", s_ready);
    end
    @(posedge clk); #1;
    line_start = 1'b0; s_valid = 1'b0; rd_en = 1'b0;
    m_occ = '0; m_cnt = 0; exp_to = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rd_opaque, rd_pix} !== {1'b1, ep}) begin
      errors++;
      $display("FAIL rd_before_clear: got opq %b pix %h, expected 1 %h", rd_opaque, rd_pix, ep);
    end
    drain();
    do_read(8'd100);
    do_read(8'd101);
  endtask

  task automatic test_reset_mid();
    do_line_start();
    send(9'd150, 32'h0000_00FF, 3'd2, 2'd2, 1'b0);
    repeat (7) void'(exp_q.pop_back());
    @(negedge clk);
    #1;
    rst = 1'b1;
    m_occ = '0; m_cnt = 0; exp_to = 1'b0;
    #2;
    checks++;
    if (lb_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_we: got %b, expected 0", lb_we);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_time_over();
    do_line_start();
    for (int k = 0; k < 35; k++) begin
      send(9'(k * 7), 32'h0000_0080, 3'd1, 2'd1, 1'b0);
    end
    drain();
    checks++;
    if (time_over !== exp_to) begin
      errors++;
      $display("FAIL time_over: got %b, expected %b", time_over, exp_to);
    end
    do_read(8'd238);
    do_line_start();
    checks++;
    if (time_over !== 1'b0) begin
      errors++;
      $display("FAIL time_over_clear: got %b, expected 0", time_over);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      lb_mem[a] = 9'd0;
      m_pix[a]  = 9'd0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_read();
    test_rw_collision();
    test_line_start_abort();
    test_reset_mid();
    test_time_over();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spr_line_writer.md
SPR_LINE_WRITER -- requirements
Module: spr_line_writer

Interface
REQ-001 Parameter: MAX_SLIVERS, 34, slivers accepted per line before time-over; used only with SPR_TIME_OVER_EN.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 line_start  in  1  one-cycle pulse; begins a new scanline.
REQ-005 s_valid  in  1  sliver offered.
REQ-006 s_ready  out  1  sliver accepted when s_valid && s_ready.
REQ-007 s_x  in  9  sliver left X, two's-complement screen coordinate mod 512.
REQ-008 s_planes  in  32  {p3,p2,p1,p0}, 8 bits each; bit 7 = leftmost pixel when not flipped.
REQ-009 s_pal  in  3  palette; s_pri  in  2  priority; s_hflip  in  1  horizontal flip.
REQ-010 lb_we  out  1; lb_addr  out  8; lb_din  out  9  write port to line buffer, format {pri[1:0],pal[2:0],color[3:0]}.
REQ-011 rd_en  in  1; rd_x  in  8  mixer read request.
REQ-012 lb_raddr  out  8  equals rd_x combinationally; lb_dout  in  9  buffer read data, valid one cycle after lb_raddr.
REQ-013 rd_pix  out  9; rd_opaque  out  1  read result; time_over  out  1  sticky overflow flag.

Function
REQ-014 States: IDLE, WRITE; 3-bit pixel counter i, 0..7, in WRITE.
REQ-015 s_ready SHALL be 1 when (IDLE or (WRITE and i==7)) and line_start==0.
REQ-016 On acceptance, the block SHALL latch all s_* fields, enter WRITE with i=0; back-to-back slivers SHALL sustain one pixel per cycle (8 cycles per sliver).
REQ-017 In WRITE, pixel i: color = {p3,p2,p1,p0} bit (hflip ? i : 7-i); x = (s_x + i) mod 512.
REQ-018 lb_we SHALL be 1 for pixel i only if color!=0, x[8]==0, and occ[x[7:0]]==0; lb_addr=x[7:0], lb_din={pri,pal,color}, registered outputs in the same cycle as counter i.
REQ-019 A 256-bit occupancy bitmap occ SHALL be set at x[7:0] on every asserted lb_we; first opaque pixel at an X wins (lower OAM index is fed first).
REQ-020 line_start SHALL clear occ in one cycle, abort any WRITE (return to IDLE, no further lb_we), and have priority over acceptance in the same cycle.
REQ-021 After i==7 with no new acceptance, state SHALL return to IDLE.
REQ-022 Read: rd_en at cycle T SHALL sample occ[rd_x]; at T+2 rd_pix = lb_dout (captured at T+1) if sampled occ==1, else 9'h000; rd_opaque = sampled occ. Without rd_en, rd_pix/rd_opaque hold.
REQ-023 Read and write to the same X in the same cycle: read SHALL return pre-write state (occ 0, rd_pix 0).
REQ-024 Read in the same cycle as line_start SHALL sample occ before clear.

Reset
REQ-025 Reset SHALL force IDLE, i=0, occ=0, lb_we=0, lb_addr=0, lb_din=0, rd_pix=0, rd_opaque=0, time_over=0, sliver count=0.
REQ-026 Reset mid-sliver SHALL discard it; no lb_we after reset deasserts until a new acceptance.

Configuration
REQ-027 Macro SPR_TIME_OVER_EN: when defined, a 6-bit counter SHALL count acceptances since line_start; slivers beyond MAX_SLIVERS SHALL still be accepted (s_ready unchanged) but produce no lb_we, and time_over SHALL set on the first dropped sliver and hold until line_start.
REQ-028 When SPR_TIME_OVER_EN is undefined, no counter SHALL exist, all slivers SHALL be written, time_over SHALL be constant 0.

Verification
REQ-029 s_x=10, planes p0=8'h80 others 0, pal=3, pri=2, hflip=0 -> one lb_we at addr 10, lb_din=9'b10_011_0001; 7 cycles lb_we=0.
REQ-030 Same sliver with hflip=1 -> single write at addr 17; second sliver p0=8'hFF at s_x=10 -> writes 11..17 and 10 skipped? no: 10..16 written except 17 skipped (occupied).
REQ-031 s_x=9'h1FC (-4), p0=8'hFF -> writes at addr 0..3 only; s_x=252, p0=8'hFF -> writes 252..255 only.
REQ-032 line_start asserted at i=3 of a sliver with s_valid high -> no lb_we from i=4 on, s_ready=0 that cycle, occ cleared, read of a previously written X returns rd_opaque=0.
REQ-033 After writing X=40 with 9'h1A5, rd_en with rd_x=40 at T -> rd_pix=9'h1A5, rd_opaque=1 at T+2; rd_x=41 -> rd_pix=0, rd_opaque=0.
REQ-034 With SPR_TIME_OVER_EN, 35 opaque slivers at distinct X in one line -> 35th produces no lb_we, time_over=1 until next line_start; without macro, 35th is written and time_over stays 0.
